avg_frame_buffer: RTL and testbench

Downstream stage of the Average_Filter in the radar DSP chain. Captures each averaged pair (out1, out2) when the filter raises out_ready, packs the pair into a 24-bit word and writes it into a two-bank ping-pong buffer of FRAME_LEN words per bank. Each full bank is streamed out as one frame over a valid/ready handshake to the next consumer (FFT or UART packer). A sticky overflow flag is set if the filter outruns the consumer.

---
 rtl/avg_frame_buffer.sv | 148 ++++++++++++++
 tb/tb_avg_frame_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_frame_buffer.sv
// Ping-pong frame buffer between Average_Filter and the FFT/UART consumer.
// Define AVG_BUF_DIFF_EN to store the signed in1-in2 difference instead of the pair.
module avg_frame_buffer #(
   parameter int FRAME_LEN = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_ready,
   input  logic [11:0] in1,
   input  logic [11:0] in2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [23:0] out_data,
   output logic        out_last,
   output logic [15:0] frame_count,
   output logic        overflow
);

   localparam int AW = $clog2(FRAME_LEN);
   localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

   state_t state, state_n;

   logic          in_ready_d;
   logic          capture;
   logic          wr_en;
   logic [23:0]   word;
   logic [AW-1:0] wr_idx;
   logic          wr_bank;
   logic [1:0]    bank_full, bank_full_n;
   logic [AW-1:0] rd_idx, rd_inc;
   logic          rd_bank, rd_next;
   logic          rd_en, start, load_out, release_bank;
   logic [AW:0]   rd_addr;
   logic [23:0]   ram_q;
   logic [23:0]   mem [2*FRAME_LEN];

   assign capture = in_ready & ~in_ready_d;
   assign wr_en   = capture & ~bank_full[wr_bank];
   assign rd_inc  = rd_idx + 1'b1;

`ifdef AVG_BUF_DIFF_EN
   logic [12:0] diff;
   assign diff = {1'b0, in1} - {1'b0, in2};
   assign word = {{11{diff[12]}}, diff};
`else
   assign word = {in2, in1};
`endif

   // ram_q always holds the word at rd_idx, one ahead of out_data
   always_comb begin
      state_n      = state;
      rd_en        = 1'b0;
      start        = 1'b0;
      load_out     = 1'b0;
      release_bank = 1'b0;
      rd_addr      = {rd_next, {AW{1'b0}}};
      unique case (state)
         IDLE: begin
            if (bank_full[rd_next]) begin
               rd_en   = 1'b1;
               start   = 1'b1;
               state_n = PRIME;
            end
         end
         PRIME: begin
            rd_en    = 1'b1;
            rd_addr  = {rd_bank, rd_inc};
            load_out = 1'b1;
            state_n  = STREAM;
         end
         STREAM: begin
            if (out_valid && out_ready) begin
               if (out_last) begin
                  release_bank = 1'b1;
                  state_n      = IDLE;
               end else begin
                  rd_en    = 1'b1;
                  rd_addr  = {rd_bank, rd_inc};
                  load_out = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bank_full_n = bank_full;
      if (release_bank) bank_full_n[rd_bank] = 1'b0;
      if (wr_en && wr_idx == LAST) bank_full_n[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready_d  <= 1'b0;
         wr_idx      <= '0;
         wr_bank     <= 1'b0;
         bank_full   <= 2'b00;
         rd_idx      <= '0;
         rd_bank     <= 1'b0;
         rd_next     <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_data    <= '0;
         frame_count <= '0;
         overflow    <= 1'b0;
      end else begin
         in_ready_d <= in_ready;
         bank_full  <= bank_full_n;
         if (capture && bank_full[wr_bank]) overflow <= 1'b1;
         if (wr_en) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_idx == LAST) wr_bank <= ~wr_bank;
         end
         if (start) begin
            rd_bank <= rd_next;
            rd_idx  <= '0;
         end
         if (load_out) begin
            out_data  <= ram_q;
            out_last  <= (rd_idx == LAST);
            out_valid <= 1'b1;
            rd_idx    <= rd_inc;
         end
         if (release_bank) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_count <= frame_count + 16'd1;
            rd_next     <= ~rd_next;
         end
      end
   end

   // Storage is not reset; a reset only abandons whatever it held
   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem[{wr_bank, wr_idx}] <= word;
      if (rd_en) ram_q <= mem[rd_addr];
   end

endmodule

// File: tb/tb_avg_frame_buffer.sv
// Directed bench for avg_frame_buffer: framing, backpressure, edge detect,
// overflow, mid-frame reset and the optional difference packing.
module tb_avg_frame_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_ready;
   logic [11:0] in1;
   logic [11:0] in2;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic        out_last;
   logic [15:0] frame_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   logic [23:0] got_data[$];
   logic        got_last[$];
   int          stalls_bad;
   int          cycles;

   always #5 clk = ~clk;

   avg_frame_buffer #(.FRAME_LEN(16)) dut (
      .clk(clk),
      .reset(reset),
      .in_ready(in_ready),
      .in1(in1),
      .in2(in2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
      .frame_count(frame_count),
      .overflow(overflow)
   );

   function automatic logic [23:0] pack(input logic [11:0] a, input logic [11:0] b);
`ifdef AVG_BUF_DIFF_EN
      int d;
      d = int'(a) - int'(b);
      return d[23:0];
`else
      return {b, a};
`endif
   endfunction

   task automatic cap(input logic [11:0] a, input logic [11:0] b);
      @(posedge clk); #1;
      in1 = a;
      in2 = b;
      in_ready = 1'b1;
      @(posedge clk); #1;
      in_ready = 1'b0;
   endtask

   task automatic collect(input int n, input logic [3:0] pat);
      logic        prev_stall;
      logic [23:0] pd;
      logic        pl;
      got_data.delete();
      got_last.delete();
      stalls_bad = 0;
      cycles = 0;
      prev_stall = 1'b0;
      pd = '0;
      pl = 1'b0;
      while (got_data.size() < n && cycles < n * 8 + 20) begin
         @(negedge clk);
         out_ready = pat[cycles % 4];
         #1;
         cycles++;
         if (prev_stall && (!out_valid || out_data !== pd || out_last !== pl))
            stalls_bad++;
         prev_stall = out_valid && !out_ready;
         pd = out_data;
         pl = out_last;
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      in_ready = 1'b0;
      out_ready = 1'b0;
      in1 = '0;
      in2 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %0b want 0", out_valid);
      end
      checks++;
      if (out_last !== 1'b0) begin
         errors++; $display("FAIL reset_last got %0b want 0", out_last);
      end
      checks++;
      if (out_data !== 24'h0) begin
         errors++; $display("FAIL reset_data got %h want 000000", out_data);
      end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++; $display("FAIL reset_count got %0d want 0", frame_count);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_ovf got %0b want 0", overflow);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      for (int k = 0; k < 16; k++) cap(12'(k), 12'(12'h800 + k));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL lat_idle got %0b want 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL lat_prime got %0b want 0", out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL lat_valid got %0b want 1", out_valid);
      end
      collect(16, 4'b1111);
      checks++;
      if (cycles != 16) begin
         errors++; $display("FAIL basic_cycles got %0d want 16", cycles);
      end
      checks++;
      if (got_data.size() != 16) begin
         errors++; $display("FAIL basic_size got %0d want 16", got_data.size());
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_data[i] !== pack(12'(i), 12'(12'h800 + i))) begin
            errors++;
            $display("FAIL basic_word%0d got %h want %h", i, got_data[i], pack(12'(i), 12'(12'h800 + i)));
         end
         checks++;
         if (got_last[i] !== (i == 15)) begin
            errors++; $display("FAIL basic_last%0d got %0b", i, got_last[i]);
         end
      end
      checks++;
      if (frame_count !== 16'd1) begin
         errors++; $display("FAIL basic_count got %0d want 1", frame_count);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_idle got %0b want 0", out_valid);
      end
   endtask

   task automatic test_backpressure;
      for (int k = 0; k < 16; k++) cap(12'(12'h100 + k), 12'(12'h200 + k));
      collect(16, 4'b1001);
      checks++;
      if (got_data.size() != 16) begin
         errors++; $display("FAIL bp_size got %0d want 16", got_data.size());
      end
      checks++;
      if (stalls_bad != 0) begin
         errors++; $display("FAIL bp_stable got %0d changes want 0", stalls_bad);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_data[i] !== pack(12'(12'h100 + i), 12'(12'h200 + i))) begin
            errors++;
            $display("FAIL bp_word%0d got %h want %h", i, got_data[i], pack(12'(12'h100 + i), 12'(12'h200 + i)));
         end
         checks++;
         if (got_last[i] !== (i == 15)) begin
            errors++; $display("FAIL bp_last%0d got %0b", i, got_last[i]);
         end
      end
      checks++;
      if (frame_count !== 16'd2) begin
         errors++; $display("FAIL bp_count got %0d want 2", frame_count);
      end
   endtask

   task automatic test_edge;
      @(posedge clk); #1;
      in1 = 12'h0AA;
      in2 = 12'h055;
      in_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      in_ready = 1'b0;
      for (int k = 1; k < 16; k++) cap(12'(12'h0B0 + k), 12'(12'h060 + k));
      collect(16, 4'b1111);
      checks++;
      if (got_data[0] !== pack(12'h0AA, 12'h055)) begin
         errors++; $display("FAIL edge_word0 got %h want %h", got_data[0], pack(12'h0AA, 12'h055));
      end
      for (int i = 1; i < 16; i++) begin
         checks++;
         if (got_data[i] !== pack(12'(12'h0B0 + i), 12'(12'h060 + i))) begin
            errors++;
            $display("FAIL edge_word%0d got %h want %h", i, got_data[i], pack(12'(12'h0B0 + i), 12'(12'h060 + i)));
         end
      end
      checks++;
      if (got_last[15] !== 1'b1) begin
         errors++; $display("FAIL edge_last got %0b want 1", got_last[15]);
      end
      checks++;
      if (frame_count !== 16'd3) begin
         errors++; $display("FAIL edge_count got %0d want 3", frame_count);
      end
   endtask

   task automatic test_overflow;
      out_ready = 1'b0;
      for (int k = 0; k < 32; k++) cap(12'(k), 12'(12'h300 + k));
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_early got %0b want 0", overflow);
      end
      cap(12'd32, 12'h320);
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_set got %0b want 1", overflow);
      end
      collect(32, 4'b1111);
      checks++;
      if (got_data.size() != 32) begin
         errors++; $display("FAIL ovf_size got %0d want 32", got_data.size());
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (got_data[i] !== pack(12'(i), 12'(12'h300 + i))) begin
            errors++;
            $display("FAIL ovf_word%0d got %h want %h", i, got_data[i], pack(12'(i), 12'(12'h300 + i)));
         end
         checks++;
         if (got_last[i] !== (i == 15 || i == 31)) begin
            errors++; $display("FAIL ovf_last%0d got %0b", i, got_last[i]);
         end
      end
      checks++;
      if (frame_count !== 16'd5) begin
         errors++; $display("FAIL ovf_count got %0d want 5", frame_count);
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky got %0b want 1", overflow);
      end
   endtask

   task automatic test_reset_mid;
      for (int k = 0; k < 7; k++) cap(12'hEEE, 12'(12'hD00 + k));
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid got %0b want 0", out_valid);
      end
      checks++;
      if (out_last !== 1'b0) begin
         errors++; $display("FAIL rst_last got %0b want 0", out_last);
      end
      checks++;
      if (out_data !== 24'h0) begin
         errors++; $display("FAIL rst_data got %h want 000000", out_data);
      end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++; $display("FAIL rst_count got %0d want 0", frame_count);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL rst_ovf got %0b want 0", overflow);
      end
      reset = 1'b0;
      for (int k = 0; k < 16; k++) cap(12'(12'h400 + k), 12'(12'h500 + k));
      collect(16, 4'b1111);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got_data[i] !== pack(12'(12'h400 + i), 12'(12'h500 + i))) begin
            errors++;
            $display("FAIL rst_word%0d got %h want %h", i, got_data[i], pack(12'(12'h400 + i), 12'(12'h500 + i)));
         end
      end
      checks++;
      if (got_last[15] !== 1'b1) begin
         errors++; $display("FAIL rst_lastw got %0b want 1", got_last[15]);
      end
      checks++;
      if (frame_count !== 16'd1) begin
         errors++; $display("FAIL rst_frames got %0d want 1", frame_count);
      end
   endtask

`ifdef AVG_BUF_DIFF_EN
   task automatic test_diff;
      cap(12'h000, 12'hFFF);
      cap(12'hFFF, 12'h000);
      for (int k = 2; k < 16; k++) cap(12'(k), 12'h000);
      collect(16, 4'b1111);
      checks++;
      if (got_data[0] !== 24'hFFF001) begin
         errors++; $display("FAIL diff_neg got %h want fff001", got_data[0]);
      end
      checks++;
      if (got_data[1] !== 24'h000FFF) begin
         errors++; $display("FAIL diff_pos got %h want 000fff", got_data[1]);
      end
      checks++;
      if (frame_count !== 16'd2) begin
         errors++; $display("FAIL diff_count got %0d want 2", frame_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_edge();
      test_overflow();
      test_reset_mid();
`ifdef AVG_BUF_DIFF_EN
      test_diff();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
